// File: rtl/sd_fifo_xfer_sched.sv
// AXI-side block scheduler for the SD/eMMC TX/RX async FIFO pair.
// Gates DMA pushes/pops per block and hands blocks to the SD engine via go/done.
module sd_fifo_xfer_sched #(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 128,
    parameter int BLK_CNT_W  = 16
) (
    input  logic                 aclk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic                 cfg_dir,
    input  logic [7:0]           cfg_blk_words,
    input  logic [BLK_CNT_W-1:0] cfg_blk_cnt,
    input  logic                 cfg_abort,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DW-1:0]        m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic                 tx_full,
    output logic [DW-1:0]        tx_data,
    output logic                 tx_wr_en_n,
    input  logic                 rx_empty,
    input  logic [DW-1:0]        rx_data,
    output logic                 rx_rd_en_n,
    output logic                 sd_blk_go,
    input  logic                 sd_blk_done,
    output logic                 sd_dir,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [BLK_CNT_W-1:0] blk_remaining
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TX,
        S_RX,
        S_FIN
    } state_e;

    localparam logic [31:0]          DEPTH_L = 32'(FIFO_DEPTH);
    localparam logic [BLK_CNT_W-1:0] CNT_ONE = BLK_CNT_W'(1);

    state_e               state_q, state_d;
    logic                 dir_q, dir_d;
    logic [7:0]           words_q, words_d;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [BLK_CNT_W-1:0] pushed_q, pushed_d;
    logic [BLK_CNT_W-1:0] full_q, full_d;
    logic [BLK_CNT_W-1:0] rem_q, rem_d;
    logic [7:0]           word_cnt_q, word_cnt_d;
    logic [7:0]           drain_q, drain_d;
    logic                 pending_q, pending_d;
    logic                 go_q, go_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic in_tx, in_rx, push, pop, fill, ack_ok, cfg_bad, clr;

    assign in_tx = (state_q == S_TX);
    assign in_rx = (state_q == S_RX);

    assign s_ready    = in_tx && !tx_full && (pushed_q < blk_cnt_q);
    assign push       = s_valid && s_ready;
    assign tx_wr_en_n = !push;
    assign tx_data    = s_data;

    assign m_valid    = in_rx && pending_q && !rx_empty;
    assign pop        = m_valid && m_ready;
    assign rx_rd_en_n = !pop;
    assign m_data     = rx_data;

    assign cfg_bad = (cfg_blk_words == 8'd0)
                  || ({24'd0, cfg_blk_words} > DEPTH_L)
                  || (cfg_blk_cnt == '0);

    assign fill   = push && ((word_cnt_q + 8'd1) == words_q);
    assign ack_ok = sd_blk_done && (full_q != '0);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        words_d    = words_q;
        blk_cnt_d  = blk_cnt_q;
        pushed_d   = pushed_q;
        full_d     = full_q;
        rem_d      = rem_q;
        word_cnt_d = word_cnt_q;
        drain_d    = drain_q;
        pending_d  = pending_q;
        err_d      = 1'b0;
        clr        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        dir_d     = cfg_dir;
                        words_d   = cfg_blk_words;
                        blk_cnt_d = cfg_blk_cnt;
                        rem_d     = cfg_blk_cnt;
                        state_d   = cfg_dir ? S_RX : S_TX;
                    end
                end
            end
            S_TX: begin
                if (cfg_abort) begin
                    clr     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    err_d = cfg_start || (sd_blk_done && !ack_ok);
                    if (push) word_cnt_d = fill ? 8'd0 : word_cnt_q + 8'd1;
                    if (fill) pushed_d = pushed_q + CNT_ONE;
                    if (fill && !ack_ok) full_d = full_q + CNT_ONE;
                    if (!fill && ack_ok) full_d = full_q - CNT_ONE;
                    if (ack_ok) begin
                        rem_d = rem_q - CNT_ONE;
                        if (rem_q == CNT_ONE) state_d = S_FIN;
                    end
                end
            end
            S_RX: begin
                if (cfg_abort) begin
                    clr     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    err_d = cfg_start || (sd_blk_done && pending_q);
                    if (sd_blk_done && !pending_q) begin
                        pending_d = 1'b1;
                        drain_d   = words_q;
                    end
                    if (pop) begin
                        drain_d = drain_q - 8'd1;
                        if (drain_q == 8'd1) begin
                            pending_d = 1'b0;
                            rem_d     = rem_q - CNT_ONE;
                            if (rem_q == CNT_ONE) state_d = S_FIN;
                        end
                    end
                end
            end
            S_FIN: begin
                err_d   = cfg_start;
                clr     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clr) begin
            pushed_d   = '0;
            full_d     = '0;
            rem_d      = '0;
            word_cnt_d = 8'd0;
            drain_d    = 8'd0;
            pending_d  = 1'b0;
        end

        busy_d = (state_d == S_TX) || (state_d == S_RX);
        done_d = (state_d == S_FIN);
        // go follows next-cycle block accounting so it lines up with the counters
        go_d   = ((state_d == S_TX) && (full_d != '0))
              || ((state_d == S_RX) && !pending_d);
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            words_q    <= 8'd0;
            blk_cnt_q  <= '0;
            pushed_q   <= '0;
            full_q     <= '0;
            rem_q      <= '0;
            word_cnt_q <= 8'd0;
            drain_q    <= 8'd0;
            pending_q  <= 1'b0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            words_q    <= words_d;
            blk_cnt_q  <= blk_cnt_d;
            pushed_q   <= pushed_d;
            full_q     <= full_d;
            rem_q      <= rem_d;
            word_cnt_q <= word_cnt_d;
            drain_q    <= drain_d;
            pending_q  <= pending_d;
            go_q       <= go_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign sd_blk_go     = go_q;
    assign sd_dir        = dir_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign blk_remaining = rem_q;

endmodule

// File: tb/tb_sd_fifo_xfer_sched.sv
// Directed bench for sd_fifo_xfer_sched: TX/RX block flow, errors, abort, reset.
module tb_sd_fifo_xfer_sched;

    localparam int DW = 32;
    localparam int BW = 16;

    logic          aclk = 1'b0;
    logic          rst_n;
    logic          cfg_start, cfg_dir, cfg_abort;
    logic [7:0]    cfg_blk_words;
    logic [BW-1:0] cfg_blk_cnt;
    logic [DW-1:0] s_data, m_data, tx_data, rx_data;
    logic          s_valid, s_ready, m_valid, m_ready;
    logic          tx_full, tx_wr_en_n, rx_empty, rx_rd_en_n;
    logic          sd_blk_go, sd_blk_done, sd_dir, busy, done, err;
    logic [BW-1:0] blk_remaining;

    int vectors = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    sd_fifo_xfer_sched #(.DW(DW), .FIFO_DEPTH(128), .BLK_CNT_W(BW)) dut (
        .aclk(aclk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_dir(cfg_dir),
        .cfg_blk_words(cfg_blk_words), .cfg_blk_cnt(cfg_blk_cnt),
        .cfg_abort(cfg_abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .tx_full(tx_full), .tx_data(tx_data), .tx_wr_en_n(tx_wr_en_n),
        .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd_en_n(rx_rd_en_n),
        .sd_blk_go(sd_blk_go), .sd_blk_done(sd_blk_done), .sd_dir(sd_dir),
        .busy(busy), .done(done), .err(err), .blk_remaining(blk_remaining)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic start(input logic dir, input logic [7:0] w,
                         input logic [BW-1:0] n);
        cfg_start     = 1'b1;
        cfg_dir       = dir;
        cfg_blk_words = w;
        cfg_blk_cnt   = n;
        step();
        cfg_start = 1'b0;
    endtask

    int pushes, gcnt, acks, pops, blks;
    logic ack_prev, fin, prev_go;

    initial begin
        rst_n = 1'b0;
        cfg_start = 0; cfg_dir = 0; cfg_abort = 0;
        cfg_blk_words = 0; cfg_blk_cnt = 0;
        s_data = 0; s_valid = 0; m_ready = 0;
        tx_full = 0; rx_empty = 1; rx_data = 0; sd_blk_done = 0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_tx_wr_en_n", 32'(tx_wr_en_n), 1);
        chk("rst_rx_rd_en_n", 32'(rx_rd_en_n), 1);
        chk("rst_go", 32'(sd_blk_go), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_sd_dir", 32'(sd_dir), 0);
        chk("rst_rem", 32'(blk_remaining), 0);
        #2 rst_n = 1'b1;
        step();

        // TX: 2 blocks of 128, engine acks 10 cycles after go
        start(1'b0, 8'd128, 16'd2);
        chk("tx_busy", 32'(busy), 1);
        chk("tx_rem_start", 32'(blk_remaining), 2);
        s_valid = 1'b1;
        s_data  = 32'h5A5A_0001;
        #1;
        chk("tx_s_ready", 32'(s_ready), 1);
        chk("tx_wr_en_n", 32'(tx_wr_en_n), 0);
        chk("tx_data", tx_data, 32'h5A5A_0001);
        pushes = 0; gcnt = 0; acks = 0; ack_prev = 0; fin = 0; prev_go = 0;
        for (int c = 0; c < 400; c++) begin
            if (ack_prev) begin
                acks++;
                chk("tx_rem_after_ack", 32'(blk_remaining), 32'(2 - acks));
                if (acks == 2) chk("tx_done_after_ack2", 32'(done), 1);
            end
            if (done) begin
                fin = 1;
                break;
            end
            if (sd_blk_go && !prev_go)
                chk("tx_go_rise_pushes", 32'(pushes), 32'(128 * (acks + 1)));
            prev_go = sd_blk_go;
            ack_prev = 0;
            sd_blk_done = 1'b0;
            if (sd_blk_go) begin
                gcnt++;
                if (gcnt == 10) begin
                    sd_blk_done = 1'b1;
                    ack_prev = 1;
                    gcnt = 0;
                end
            end
            if (!tx_wr_en_n) pushes++;
            step();
        end
        sd_blk_done = 1'b0;
        s_valid = 1'b0;
        chk("tx_fin_seen", 32'(fin), 1);
        chk("tx_total_pushes", 32'(pushes), 256);
        chk("tx_busy_fin", 32'(busy), 0);
        step();
        chk("tx_done_pulse_end", 32'(done), 0);

        // TX backpressure: 3 words, 5 full cycles, 5 more words
        start(1'b0, 8'd8, 16'd1);
        s_valid = 1'b1;
        step(); step(); step();
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_s_ready", 32'(s_ready), 0);
            chk("bp_wr_en_n", 32'(tx_wr_en_n), 1);
            step();
        end
        tx_full = 1'b0;
        step(); step(); step(); step();
        chk("bp_go_before_8th", 32'(sd_blk_go), 0);
        step();
        chk("bp_go_after_8th", 32'(sd_blk_go), 1);
        chk("bp_s_ready_blocked", 32'(s_ready), 0);
        s_valid = 1'b0;
        sd_blk_done = 1'b1;
        step();
        sd_blk_done = 1'b0;
        chk("bp_done", 32'(done), 1);
        chk("bp_rem", 32'(blk_remaining), 0);
        step();

        // config errors
        start(1'b0, 8'd4, 16'd0);
        chk("err_cnt0", 32'(err), 1);
        chk("err_cnt0_busy", 32'(busy), 0);
        step();
        chk("err_pulse_one", 32'(err), 0);
        start(1'b0, 8'd129, 16'd1);
        chk("err_words129", 32'(err), 1);
        chk("err_words129_busy", 32'(busy), 0);
        start(1'b0, 8'd0, 16'd1);
        chk("err_words0", 32'(err), 1);

        // spurious ack in TX with nothing full
        start(1'b0, 8'd4, 16'd1);
        sd_blk_done = 1'b1;
        step();
        sd_blk_done = 1'b0;
        chk("tx_bad_ack_err", 32'(err), 1);
        chk("tx_bad_ack_rem", 32'(blk_remaining), 1);
        chk("tx_bad_ack_busy", 32'(busy), 1);
        chk("tx_bad_ack_go", 32'(sd_blk_go), 0);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("tx_abort_busy", 32'(busy), 0);

        // RX: 3 blocks of 4 words, m_ready toggling
        start(1'b1, 8'd4, 16'd3);
        chk("rx_busy", 32'(busy), 1);
        chk("rx_sd_dir", 32'(sd_dir), 1);
        rx_empty = 1'b0;
        pops = 0; blks = 0; prev_go = 0; fin = 0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                fin = 1;
                break;
            end
            if (sd_blk_go && !prev_go) begin
                chk("rx_go_rise_pops", 32'(pops), 32'(4 * blks));
                chk("rx_go_rise_rem", 32'(blk_remaining), 32'(3 - blks));
                blks++;
            end
            prev_go = sd_blk_go;
            sd_blk_done = sd_blk_go;
            m_ready = c[0];
            rx_data = 32'hA000 + 32'(pops);
            #1;
            if (!rx_rd_en_n) begin
                chk("rx_m_data", m_data, 32'hA000 + 32'(pops));
                pops++;
            end
            step();
        end
        sd_blk_done = 1'b0;
        m_ready = 1'b0;
        chk("rx_fin_seen", 32'(fin), 1);
        chk("rx_total_pops", 32'(pops), 12);
        chk("rx_rem_end", 32'(blk_remaining), 0);
        chk("rx_busy_fin", 32'(busy), 0);
        step();
        chk("rx_done_pulse_end", 32'(done), 0);

        // RX double ack then abort after 2 of 4 pops
        start(1'b1, 8'd4, 16'd1);
        chk("ab_go", 32'(sd_blk_go), 1);
        sd_blk_done = 1'b1;
        step();
        chk("ab_go_drop", 32'(sd_blk_go), 0);
        step();
        sd_blk_done = 1'b0;
        chk("rx_double_ack_err", 32'(err), 1);
        chk("rx_double_ack_rem", 32'(blk_remaining), 1);
        m_ready = 1'b1;
        #1;
        chk("ab_m_valid", 32'(m_valid), 1);
        step(); step();
        m_ready = 1'b0;
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_m_valid_off", 32'(m_valid), 0);
        chk("ab_rem", 32'(blk_remaining), 0);
        chk("ab_go_off", 32'(sd_blk_go), 0);
        chk("ab_no_done", 32'(done), 0);
        step();
        chk("ab_no_done_late", 32'(done), 0);
        start(1'b0, 8'd1, 16'd1);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_rem", 32'(blk_remaining), 1);
        chk("restart_err", 32'(err), 0);
        chk("restart_dir", 32'(sd_dir), 0);

        // async reset mid-TX, between clock edges
        s_valid = 1'b1;
        step();
        chk("pre_rst_go", 32'(sd_blk_go), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_go", 32'(sd_blk_go), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rem", 32'(blk_remaining), 0);
        chk("arst_s_ready", 32'(s_ready), 0);
        chk("arst_wr_en_n", 32'(tx_wr_en_n), 1);
        chk("arst_done", 32'(done), 0);
        s_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
